comparador_dms_multi: RTL and testbench

COMPARADOR_DMS_MULTI -- requirements
Module: comparador_dms_multi

---
 rtl/comparador_dms_pkg.sv | 22 ++
 rtl/comparador_dms_ch.sv | 74 +++++++
 rtl/comparador_dms_multi.sv | 120 ++++++++++++
 tb/tb_comparador_dms_multi.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparador_dms_pkg.sv
// Shared defaults, direction encoding and sizing helper for the multi-channel
// hysteretic comparator with debounce and event reporting.
package comparador_dms_pkg;

  localparam int  N_CH_DEF     = 4;
  localparam real HYST_DEF     = 0.02;
  localparam int  DEBOUNCE_DEF = 3;
  localparam real VDD_DEF      = 1.0;

  // Wide enough for DEBOUNCE up to 255.
  localparam int  CNT_W        = 8;

  typedef enum logic {
    FALL = 1'b0,
    RISE = 1'b1
  } dir_e;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comparador_dms_ch.sv
// One comparator channel: hysteresis around zero differential, debounce of
// state flips, and the analog rendering of the accepted state.
module comparador_dms_ch
  import comparador_dms_pkg::*;
#(
  parameter real HYST     = HYST_DEF,
  parameter int  DEBOUNCE = DEBOUNCE_DEF,
  parameter real VDD      = VDD_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  real  p_i,
  input  real  n_i,
  output real  c_o,
  output logic state_o,
  output logic flip_o
);

  // A flip is accepted on the sample that would bring the count to DEBOUNCE.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  real              diff;
  logic             raw;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    diff    = p_i - n_i;
    raw     = state_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    flip_o  = 1'b0;

    if (state_q) begin
      if (diff < -HYST / 2.0) raw = 1'b0;
    end else begin
      if (diff > HYST / 2.0) raw = 1'b1;
    end

    if (!en_i) begin
      state_d = 1'b0;
      cnt_d   = '0;
    end else if (raw != state_q) begin
      if (cnt_q >= CNT_LAST) begin
        state_d = ~state_q;
        cnt_d   = '0;
        flip_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign c_o     = state_q ? VDD : 0.0;

endmodule

// File: rtl/comparador_dms_multi.sv
// N_CH debounced hysteretic comparators with a valid/ready event port that
// reports accepted flips, lowest channel first, plus a sticky overwrite flag.
module comparador_dms_multi
  import comparador_dms_pkg::*;
#(
  parameter int  N_CH     = N_CH_DEF,
  parameter real HYST     = HYST_DEF,
  parameter int  DEBOUNCE = DEBOUNCE_DEF,
  parameter real VDD      = VDD_DEF,
  localparam int CH_W     = ch_idx_w(N_CH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] en_i,
  input  real             p_i [N_CH],
  input  real             n_i [N_CH],
  output real             c_o [N_CH],
  output logic [N_CH-1:0] c_d_o,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [CH_W-1:0] evt_ch_o,
  output logic            evt_dir_o,
  output logic            ovf_o,
  input  logic            clr_ovf_i
);

  logic [N_CH-1:0] ch_state;
  logic [N_CH-1:0] ch_flip;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    comparador_dms_ch #(
      .HYST     (HYST),
      .DEBOUNCE (DEBOUNCE),
      .VDD      (VDD)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (en_i[g]),
      .p_i     (p_i[g]),
      .n_i     (n_i[g]),
      .c_o     (c_o[g]),
      .state_o (ch_state[g]),
      .flip_o  (ch_flip[g])
    );
  end

  assign c_d_o = ch_state;

  logic [N_CH-1:0] pending_q, pending_d;
  dir_e            dir_q [N_CH];
  dir_e            dir_d [N_CH];
  logic            ovf_q, ovf_d;
  logic            hold_q, hold_d;
  logic [CH_W-1:0] hold_ch_q, hold_ch_d;

  logic [CH_W-1:0] lowest;
  logic [CH_W-1:0] cur_sel;
  logic            accept;
  logic            ovf_set;

  // A channel shown but not yet accepted keeps the port until taken, so a
  // lower channel becoming pending cannot swap it out under the consumer.
  always_comb begin
    lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest = CH_W'(i);
    end
    cur_sel = (hold_q && pending_q[hold_ch_q]) ? hold_ch_q : lowest;
  end

  assign evt_valid_o = |pending_q;
  assign accept      = evt_valid_o & evt_ready_i;
  assign evt_ch_o    = cur_sel;
  assign evt_dir_o   = evt_valid_o && (dir_q[cur_sel] == RISE);
  assign ovf_o       = ovf_q;

  always_comb begin
    pending_d = pending_q;
    dir_d     = dir_q;
    ovf_set   = 1'b0;

    for (int i = 0; i < N_CH; i++) begin
      if (!en_i[i]) begin
        pending_d[i] = 1'b0;
        dir_d[i]     = FALL;
      end else if (ch_flip[i]) begin
        // Direction is the state being entered, i.e. the inverse of the current one.
        pending_d[i] = 1'b1;
        dir_d[i]     = ch_state[i] ? FALL : RISE;
        if (pending_q[i] && !(accept && (cur_sel == CH_W'(i)))) ovf_set = 1'b1;
      end else if (accept && (cur_sel == CH_W'(i))) begin
        pending_d[i] = 1'b0;
      end
    end

    if (ovf_set)        ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
    else                ovf_d = ovf_q;

    hold_d    = evt_valid_o && !evt_ready_i;
    hold_ch_d = cur_sel;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      ovf_q     <= 1'b0;
      hold_q    <= 1'b0;
      hold_ch_q <= '0;
      for (int i = 0; i < N_CH; i++) dir_q[i] <= FALL;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      hold_q    <= hold_d;
      hold_ch_q <= hold_ch_d;
      dir_q     <= dir_d;
    end
  end

endmodule

// File: tb/tb_comparador_dms_multi.sv
// Directed scenarios plus randomized traffic for comparador_dms_multi, checked
// every cycle against a behavioural model of the comparator and event port.
module tb_comparador_dms_multi;
  import comparador_dms_pkg::*;

  localparam int  N_CH = N_CH_DEF;
  localparam int  CH_W = ch_idx_w(N_CH_DEF);
  localparam real HYST = HYST_DEF;
  localparam int  DB   = DEBOUNCE_DEF;
  localparam real VDD  = VDD_DEF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] en;
  real             p [N_CH];
  real             n [N_CH];
  real             c_o [N_CH];
  logic [N_CH-1:0] c_d;
  logic            evt_valid;
  logic            ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_dir;
  logic            ovf;
  logic            clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit m_state [N_CH];
  int m_run   [N_CH];
  bit m_pend  [N_CH];
  bit m_dir   [N_CH];
  bit m_ovf;
  bit m_hold;
  int m_hold_ch;

  always #5 clk = ~clk;

  comparador_dms_multi dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .p_i         (p),
    .n_i         (n),
    .c_o         (c_o),
    .c_d_o       (c_d),
    .evt_valid_o (evt_valid),
    .evt_ready_i (ready),
    .evt_ch_o    (evt_ch),
    .evt_dir_o   (evt_dir),
    .ovf_o       (ovf),
    .clr_ovf_i   (clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int c_code(input real v);
    if (v == VDD) return 1;
    if (v == 0.0) return 0;
    return 2;
  endfunction

  function automatic bit any_pending();
    for (int c = 0; c < N_CH; c++) if (m_pend[c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int presented();
    if (m_hold && m_pend[m_hold_ch]) return m_hold_ch;
    for (int c = 0; c < N_CH; c++) if (m_pend[c]) return c;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_state[c] = 0; m_run[c] = 0; m_pend[c] = 0; m_dir[c] = 0;
    end
    m_ovf = 0; m_hold = 0; m_hold_ch = 0;
  endtask

  task automatic model_step();
    bit valid, acc, ovf_new;
    int pres;
    if (!rst_n) begin
      model_reset();
      return;
    end
    valid   = any_pending();
    pres    = presented();
    acc     = valid && ready;
    ovf_new = 0;
    for (int c = 0; c < N_CH; c++) begin
      real d;
      bit  want, flip, taken;
      d     = p[c] - n[c];
      flip  = 0;
      taken = acc && (pres == c);
      // Wanted level: leave 0 only above +HYST/2, leave 1 only below -HYST/2.
      want  = m_state[c] ? !(d < -HYST / 2.0) : (d > HYST / 2.0);
      if (!en[c]) begin
        m_state[c] = 0; m_run[c] = 0; m_pend[c] = 0; m_dir[c] = 0;
      end else begin
        m_run[c] = (want != m_state[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == DB) begin
          m_state[c] = want;
          m_run[c]   = 0;
          flip       = 1;
        end
        if (flip) begin
          if (m_pend[c] && !taken) ovf_new = 1;
          m_pend[c] = 1;
          m_dir[c]  = m_state[c];
        end else if (taken) begin
          m_pend[c] = 0;
        end
      end
    end
    m_ovf     = ovf_new || (m_ovf && !clr);
    m_hold    = valid && !ready;
    m_hold_ch = pres;
  endtask

  task automatic compare_all();
    int pres;
    pres = presented();
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("c_d_o[%0d]", c), 32'(c_d[c]), 32'(m_state[c]));
      check($sformatf("c_o[%0d]", c), c_code(c_o[c]), 32'(m_state[c]));
    end
    check("evt_valid", 32'(evt_valid), 32'(any_pending()));
    check("evt_ch", 32'(evt_ch), pres);
    check("evt_dir", 32'(evt_dir), any_pending() ? 32'(m_dir[pres]) : 0);
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic tick(input int cycles = 1);
    repeat (cycles) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  endtask

  task automatic set_all(input real pv, input real nv);
    for (int c = 0; c < N_CH; c++) begin
      p[c] = pv;
      n[c] = nv;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(evt_valid), 0);
    check("async_rst_cd", 32'(c_d), 0);
    check("async_rst_ovf", 32'(ovf), 0);
    check("async_rst_ch", 32'(evt_ch), 0);
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = '1;
    ready = 1'b0;
    clr   = 1'b0;
    set_all(0.8, 0.2);
    model_reset();

    // Reset holds outputs low while a large positive differential is present.
    #3;
    check("rst_c_o0", c_code(c_o[0]), 0);
    check("rst_valid", 32'(evt_valid), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("rel_edge2_cd0", 32'(c_d[0]), 0);
    tick();
    check("rel_edge3_cd0", 32'(c_d[0]), 1);
    check("rel_edge3_c_o0", c_code(c_o[0]), 1);
    ready = 1'b1;
    tick(N_CH);
    ready = 1'b0;
    check("drain_valid", 32'(evt_valid), 0);

    // Hysteresis band on channel 0.
    do_reset();
    set_all(0.5, 0.5);
    p[0] = 0.505;
    tick(5);
    check("hyst_inside", 32'(c_d[0]), 0);
    p[0] = 0.515;
    tick(2);
    check("hyst_cnt2", 32'(c_d[0]), 0);
    tick();
    check("hyst_flip", 32'(c_d[0]), 1);
    check("hyst_evt_dir", 32'(evt_dir), 1);
    p[0] = 0.495;
    tick(5);
    check("hyst_no_fall", 32'(c_d[0]), 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("hyst_accepted", 32'(evt_valid), 0);

    // Two-cycle glitch on channel 1 must not flip and must clear the count.
    p[1] = 0.6;
    tick(2);
    p[1] = 0.4;
    tick(5);
    check("glitch_state", 32'(c_d[1]), 0);
    check("glitch_no_evt", 32'(evt_valid), 0);
    p[1] = 0.6;
    tick(2);
    check("glitch_cnt_cleared", 32'(c_d[1]), 0);
    p[1] = 0.5;
    tick(3);

    // Simultaneous rises on channels 2 and 0.
    do_reset();
    set_all(0.5, 0.5);
    p[0] = 0.8;
    p[2] = 0.8;
    tick(3);
    check("arb_valid", 32'(evt_valid), 1);
    check("arb_first", 32'(evt_ch), 0);
    tick(2);
    check("arb_held", 32'(evt_ch), 0);
    ready = 1'b1;
    tick();
    check("arb_second", 32'(evt_ch), 2);
    check("arb_second_valid", 32'(evt_valid), 1);
    tick();
    check("arb_drained", 32'(evt_valid), 0);
    ready = 1'b0;

    // Overwrite of an unaccepted event on channel 1.
    p[1] = 0.8;
    tick(3);
    check("ovf_rise_ch", 32'(evt_ch), 1);
    check("ovf_rise_dir", 32'(evt_dir), 1);
    check("ovf_none_yet", 32'(ovf), 0);
    p[1] = 0.2;
    tick(3);
    check("ovf_fall_dir", 32'(evt_dir), 0);
    check("ovf_set", 32'(ovf), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("ovf_drained", 32'(evt_valid), 0);

    // Disabling a set, pending channel.
    p[3] = 0.8;
    tick(3);
    check("dis_state", 32'(c_d[3]), 1);
    check("dis_pending_ch", 32'(evt_ch), 3);
    en[3] = 1'b0;
    tick();
    check("dis_c_o3", c_code(c_o[3]), 0);
    check("dis_no_evt", 32'(evt_valid), 0);
    en[3] = 1'b1;
    p[3]  = 0.5;
    tick();

    // Randomized traffic around the hysteresis band.
    set_all(0.5, 0.5);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 2) == 0) begin
        int c;
        c = $urandom_range(0, N_CH - 1);
        if ($urandom_range(0, 3) == 0)
          p[c] = ($urandom_range(0, 1) == 1) ? 0.8 : 0.2;
        else
          p[c] = 0.5 + real'(int'($urandom_range(0, 60)) - 30) * 0.001;
      end
      if ($urandom_range(0, 49) == 0) en[$urandom_range(0, N_CH - 1)] ^= 1'b1;
      ready = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
